// File: rtl/if_pkg.sv
// if_pkg: shared IF-stage types and constants for the PC register and fetch queue.
package if_pkg;
    localparam int PC_W = 30;
    localparam logic [PC_W-1:0] START_ADDR = 30'h0000BFF;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched {pc, instr} pairs between IF and ID.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     pc_write,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     id_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign out_valid = count_q != '0;
    assign pc_write  = (count_q != CW'(DEPTH)) || id_ready;
    assign push      = in_valid && pc_write && !flush;
    assign pop       = id_ready && out_valid;
    assign count     = count_q;
    // Gate the read so never-written storage cannot leak X toward ID.
    assign out_pc    = out_valid ? mem_q[head_q].pc : '0;
    assign out_instr = out_valid ? mem_q[head_q].instr : '0;

    always_comb begin
        head_d  = flush ? '0 : head_q + AW'(pop);
        tail_d  = flush ? '0 : tail_q + AW'(push);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{pc: in_pc, instr: in_instr};
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (count_q <= CW'(DEPTH));
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, streaming sequence and random traffic vs a queue model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1, in_valid = 1'b0, id_ready = 1'b0, flush = 1'b0;
    logic [29:0] in_pc = '0, out_pc;
    logic [31:0] in_instr = '0, out_instr;
    logic        pc_write, out_valid;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .pc_write(pc_write), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .id_ready(id_ready), .flush(flush), .count(count)
    );

    typedef struct packed {logic [29:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {
        bit r, v, rd, fl;
        logic [29:0] pc;
        int cnt;
        logic [29:0] opc;
        bit pw;
    } vec_t;

    ent_t q[$];
    vec_t tv[$];
    int checks = 0, errors = 0;
    bit mod_on = 0;

    function automatic logic [31:0] ins(logic [29:0] pc);
        return pc == 30'hC10 ? 32'h2402000A : 32'hA500_0000 ^ {2'b0, pc};
    endfunction

    function automatic vec_t mk(bit r, v, rd, fl, logic [29:0] pc, int cnt, logic [29:0] opc, bit pw);
        vec_t t;
        t.r = r; t.v = v; t.rd = rd; t.fl = fl; t.pc = pc; t.cnt = cnt; t.opc = opc; t.pw = pw;
        return t;
    endfunction

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    task automatic apply(bit r, v, rd, fl, logic [29:0] pc, logic [31:0] ii);
        ent_t h;
        @(negedge clk);
        reset = r; in_valid = v; id_ready = rd; flush = fl; in_pc = pc; in_instr = ii;
        #1;
        if (mod_on) begin
            h = q.size() != 0 ? q[0] : '0;
            chk("m_count", 64'(count), 64'(q.size()));
            chk("m_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("m_pc", 64'(out_pc), 64'(h.pc));
            chk("m_instr", 64'(out_instr), 64'(h.instr));
            chk("m_pcw", 64'(pc_write), 64'(q.size() != 4 || rd));
        end
    endtask

    task automatic advance();
        bit pw;
        pw = q.size() != 4 || id_ready;
        @(posedge clk);
        if (reset || flush) q.delete();
        else begin
            if (id_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && pw) q.push_back('{pc: in_pc, instr: in_instr});
        end
        if (reset) mod_on = 1;
    endtask

    initial begin
        tv.push_back(mk(0,1,0,0,30'hBFF ,0,30'h0  ,1));
        tv.push_back(mk(0,1,0,0,30'hC00 ,1,30'hBFF,1));
        tv.push_back(mk(0,1,0,0,30'hC01 ,2,30'hBFF,1));
        tv.push_back(mk(0,1,0,0,30'hC02 ,3,30'hBFF,1));
        tv.push_back(mk(0,1,0,0,30'hDEAD,4,30'hBFF,0));
        tv.push_back(mk(0,1,1,0,30'hC03 ,4,30'hBFF,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,4,30'hC00,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,3,30'hC01,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,2,30'hC02,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,1,30'hC03,1));
        tv.push_back(mk(0,0,0,0,30'h0   ,0,30'h0  ,1));
        tv.push_back(mk(0,1,0,0,30'hC10 ,0,30'h0  ,1));
        tv.push_back(mk(0,1,0,0,30'hC11 ,1,30'hC10,1));
        tv.push_back(mk(0,1,0,0,30'hC12 ,2,30'hC10,1));
        tv.push_back(mk(0,1,1,1,30'hEEE ,3,30'hC10,1));
        tv.push_back(mk(0,1,0,0,30'hD00 ,0,30'h0  ,1));
        tv.push_back(mk(0,0,0,0,30'h0   ,1,30'hD00,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,1,30'hD00,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,0,30'h0  ,1));
        tv.push_back(mk(0,0,0,0,30'h0   ,0,30'h0  ,1));
        tv.push_back(mk(0,1,0,0,30'hE00 ,0,30'h0  ,1));
        tv.push_back(mk(0,1,0,0,30'hE01 ,1,30'hE00,1));
        tv.push_back(mk(1,1,0,0,30'hE02 ,2,30'hE00,1));
        tv.push_back(mk(0,0,1,0,30'h0   ,0,30'h0  ,1));
        tv.push_back(mk(0,0,0,0,30'h0   ,0,30'h0  ,1));

        apply(1, 0, 0, 0, '0, '0);
        advance();

        foreach (tv[i]) begin
            apply(tv[i].r, tv[i].v, tv[i].rd, tv[i].fl, tv[i].pc, ins(tv[i].pc));
            chk($sformatf("t%0d_count", i), 64'(count), 64'(tv[i].cnt));
            chk($sformatf("t%0d_valid", i), 64'(out_valid), 64'(tv[i].opc != 0));
            chk($sformatf("t%0d_pc", i), 64'(out_pc), 64'(tv[i].opc));
            chk($sformatf("t%0d_instr", i), 64'(out_instr), 64'(tv[i].opc != 0 ? ins(tv[i].opc) : 32'h0));
            chk($sformatf("t%0d_pcw", i), 64'(pc_write), 64'(tv[i].pw));
            advance();
        end

        for (int k = 0; k < 10; k++) begin
            apply(0, 1, 1, 0, 30'hF00 + 30'(k), ins(30'hF00 + 30'(k)));
            if (k > 0) begin
                chk($sformatf("s%0d_count", k), 64'(count), 64'd1);
                chk($sformatf("s%0d_pc", k), 64'(out_pc), 64'(30'hF00 + 30'(k - 1)));
            end
            advance();
        end
        apply(0, 0, 1, 0, '0, '0);
        chk("s_last_pc", 64'(out_pc), 64'(30'hF09));
        advance();

        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, 30'($urandom), $urandom);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
